// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with registered one-hot grants held until release or timeout.
// Winner is the lowest set bit of the request vector rotated by the priority pointer.
module rr_arbiter_hold #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CW       = 4,
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  REQ,
    input  logic          DONE,
    output logic [N-1:0]  GNT,
    output logic [IW-1:0] GNT_IDX,
    output logic          VALID,
    output logic          TIMEOUT
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q;
    logic [IW-1:0] ptr_q;
    logic [CW-1:0] hcnt_q;

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   rot_iso;
    logic [IW-1:0]  rot_idx;
    logic [IW:0]    win_sum;
    logic [IW-1:0]  win_idx;
    logic           owner_req;
    logic           hold_max;
    logic           release_now;

    always_comb begin
        // Rotate right by ptr so the pointer position becomes bit 0 (highest priority).
        req_dbl = {REQ, REQ} >> ptr_q;
        req_rot = req_dbl[N-1:0];
        rot_iso = req_rot & ~(req_rot - N'(1));
        rot_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (rot_iso[i]) begin
                rot_idx = IW'(i);
            end
        end
        win_sum = {1'b0, rot_idx} + {1'b0, ptr_q};
        win_idx = (win_sum >= (IW+1)'(N)) ? IW'(win_sum - (IW+1)'(N)) : win_sum[IW-1:0];
    end

    always_comb begin
        owner_req   = REQ[GNT_IDX];
        hold_max    = (hcnt_q == CW'(MAX_HOLD));
        release_now = DONE || !owner_req || hold_max;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            GNT     <= '0;
            GNT_IDX <= '0;
            VALID   <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    TIMEOUT <= 1'b0;
                    if (|REQ) begin
                        state_q <= StBusy;
                        GNT     <= N'(1) << win_idx;
                        GNT_IDX <= win_idx;
                        VALID   <= 1'b1;
                        hcnt_q  <= CW'(1);
                        ptr_q   <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        state_q <= StIdle;
                        GNT     <= '0;
                        GNT_IDX <= '0;
                        VALID   <= 1'b0;
                        hcnt_q  <= '0;
                        // Timeout only when the hold limit was the sole reason to let go.
                        TIMEOUT <= !DONE && owner_req;
                    end else begin
                        // Release fires at MAX_HOLD, so this never passes the limit.
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: a cycle model of owner/pointer/hold count checked every
// cycle, plus directed scenarios with literal expected values.
module tb_rr_arbiter_hold;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 15;
    localparam int unsigned CW       = 4;
    localparam int unsigned IW       = 2;

    logic          CLK;
    logic          RESET;
    logic [N-1:0]  REQ;
    logic          DONE;
    logic [N-1:0]  GNT;
    logic [IW-1:0] GNT_IDX;
    logic          VALID;
    logic          TIMEOUT;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 0;

    // Model state: owner index (-1 when idle), hold count, pointer, timeout flag.
    int m_owner;
    int m_hold;
    int m_ptr;
    bit m_to;

    rr_arbiter_hold #(
        .N       (N),
        .MAX_HOLD(MAX_HOLD),
        .CW      (CW)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .REQ    (REQ),
        .DONE   (DONE),
        .GNT    (GNT),
        .GNT_IDX(GNT_IDX),
        .VALID  (VALID),
        .TIMEOUT(TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
        end
        return w;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_ptr   <= 0;
            m_to    <= 1'b0;
        end else if (m_owner < 0) begin
            m_to <= 1'b0;
            if (pick(REQ, m_ptr) >= 0) begin
                m_owner <= pick(REQ, m_ptr);
                m_hold  <= 1;
                m_ptr   <= (pick(REQ, m_ptr) + 1) % N;
            end
        end else if (DONE || !REQ[m_owner] || m_hold == MAX_HOLD) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_to    <= !(DONE || !REQ[m_owner]);
        end else begin
            m_hold <= m_hold + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("model_gnt", 32'(GNT), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("model_idx", 32'(GNT_IDX), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            chk("model_valid", 32'(VALID), 32'(m_owner >= 0));
            chk("model_timeout", 32'(TIMEOUT), 32'(m_to));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] rr_seq [9];

    initial begin
        rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};
        RESET = 1'b1;
        REQ   = '0;
        DONE  = 1'b0;
        #1;
        chk("reset_gnt", 32'(GNT), 32'd0);
        chk("reset_valid", 32'(VALID), 32'd0);
        chk("reset_idx", 32'(GNT_IDX), 32'd0);
        chk("reset_timeout", 32'(TIMEOUT), 32'd0);
        tick();
        tick();
        RESET  = 1'b0;
        chk_on = 1'b1;

        // Single request with a DONE pulse two cycles later.
        REQ = 4'b0100;
        tick();
        chk("single_gnt", 32'(GNT), 32'h4);
        chk("single_idx", 32'(GNT_IDX), 32'd2);
        chk("single_valid", 32'(VALID), 32'd1);
        tick();
        tick();
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        chk("single_release", 32'(GNT), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_gnt", 32'(GNT), 32'd0);
        end

        // Round robin from a fresh pointer, DONE held high.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        REQ   = 4'b1111;
        DONE  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr_seq", 32'(GNT), 32'(rr_seq[i]));
        end
        REQ = 4'b0000;
        tick();
        DONE = 1'b0;

        // Pointer is 1: grant 3, pointer wraps to 0, then 1, then 3 from pointer 2.
        REQ = 4'b1000;
        tick();
        chk("wrap_idx3", 32'(GNT_IDX), 32'd3);
        REQ  = 4'b1010;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        tick();
        chk("wrap_gnt1", 32'(GNT), 32'h2);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        tick();
        chk("wrap_gnt3", 32'(GNT), 32'h8);
        REQ  = 4'b0000;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;

        // Timeout: held exactly MAX_HOLD cycles, then a one-cycle pulse.
        REQ = 4'b0001;
        tick();
        chk("to_grant", 32'(GNT), 32'h1);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            chk("to_hold", 32'(GNT), 32'h1);
        end
        tick();
        chk("to_release", 32'(GNT), 32'd0);
        chk("to_pulse", 32'(TIMEOUT), 32'd1);
        tick();
        chk("to_regrant", 32'(GNT), 32'h1);
        chk("to_pulse_end", 32'(TIMEOUT), 32'd0);
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        chk("done_max_hold", 32'(GNT), 32'h1);
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        chk("done_max_gnt", 32'(GNT), 32'd0);
        chk("done_max_to", 32'(TIMEOUT), 32'd0);

        // Granted bit drops; other bits toggling are ignored.
        REQ = 4'b0010;
        tick();
        chk("drop_grant", 32'(GNT), 32'h2);
        REQ = 4'b1011;
        tick();
        chk("drop_ign_a", 32'(GNT), 32'h2);
        REQ = 4'b0011;
        tick();
        chk("drop_ign_b", 32'(GNT), 32'h2);
        REQ = 4'b1001;
        tick();
        chk("drop_release", 32'(GNT), 32'd0);
        chk("drop_to", 32'(TIMEOUT), 32'd0);
        REQ = 4'b0000;
        tick();

        // Reset mid-grant drops the grant immediately.
        REQ = 4'b0010;
        tick();
        chk("rst_pre", 32'(GNT), 32'h2);
        RESET = 1'b1;
        #1;
        chk("rst_mid_gnt", 32'(GNT), 32'd0);
        chk("rst_mid_valid", 32'(VALID), 32'd0);
        REQ = 4'b0000;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_idle", 32'(VALID), 32'd0);
        end

        // Pseudo-random traffic checked by the model only.
        for (int i = 0; i < 400; i++) begin
            REQ  = (i % 64 < 32) ? 4'($urandom_range(0, 15)) : (4'($urandom_range(0, 15)) | 4'b0101);
            DONE = ($urandom_range(0, 9) == 0);
            tick();
            if (i % 64 >= 32) begin
                for (int k = 0; k < 3; k++) tick();
            end
        end

        chk_on = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
